// File: rtl/weddinglight_pkg.sv
// Shared types for the wedding-light pattern sequencer.
// States, mode codes, seed kinds and bounce direction.
package weddinglight_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_NEXT
    } state_e;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    typedef enum logic [1:0] {
        SEED_ZERO,
        SEED_LSB,
        SEED_MSB
    } seed_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic seed_e seed_of(input logic [1:0] m);
        seed_e s;
        unique case (m)
            MODE_ROTL:   s = SEED_LSB;
            MODE_ROTR:   s = SEED_MSB;
            MODE_FILL:   s = SEED_ZERO;
            MODE_BOUNCE: s = SEED_LSB;
            default:     s = SEED_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/weddinglight_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 while enabled and not held,
// strobing tick on the last count of each period.
module weddinglight_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en & ~hold & ~clear & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en & ~hold) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/weddinglight_seq.sv
// Wedding-light pattern sequencer: ROTL/ROTR/FILL/BOUNCE with stop handling.
// Optional macro WEDDINGLIGHT_HOLD_EN adds a hold input that freezes RUN.
module weddinglight_seq
    import weddinglight_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int PRESCALE       = 4,
    parameter int STEPS_PER_MODE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef WEDDINGLIGHT_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] q,
    output logic [1:0]       mode,
    output logic             step_tick,
    output logic             busy
);

    localparam int SCW = $clog2(STEPS_PER_MODE + 1);
    localparam logic [SCW-1:0] LAST_STEP = SCW'(STEPS_PER_MODE - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, seed, shifted;
    logic [1:0]       mode_q, mode_d;
    dir_e             dir_q, dir_d, dir_n;
    logic [SCW-1:0]   step_q, step_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             bound, hold_w, stop_req, ps_en;

`ifdef WEDDINGLIGHT_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign ps_en    = (state_q == ST_RUN);
    assign stop_req = stop | pend_q;

    weddinglight_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (~ps_en),
        .en    (ps_en),
        .hold  (hold_w),
        .tick  (bound)
    );

    always_comb begin
        seed = '0;
        unique case (seed_of(mode_q))
            SEED_ZERO: seed = '0;
            SEED_LSB:  seed = WIDTH'(1);
            SEED_MSB:  seed = {1'b1, {(WIDTH-1){1'b0}}};
            default:   seed = '0;
        endcase
    end

    // Bounce flips direction once the moving light lands on an end bit.
    always_comb begin
        shifted = q_q;
        dir_n   = dir_q;
        unique case (mode_q)
            MODE_ROTL: shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROTR: shifted = {q_q[0], q_q[WIDTH-1:1]};
            MODE_FILL: shifted = {q_q[WIDTH-2:0], 1'b1};
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    shifted = q_q << 1;
                    if (shifted[WIDTH-1]) dir_n = DIR_RIGHT;
                end else begin
                    shifted = q_q >> 1;
                    if (shifted[0]) dir_n = DIR_LEFT;
                end
            end
            default: shifted = q_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        step_d  = step_q;
        pend_d  = 1'b0;
        tick_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                q_d = '0;
                if (start & ~stop) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                step_d = '0;
                dir_d  = DIR_LEFT;
                if (stop) begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                end else begin
                    state_d = ST_RUN;
                    q_d     = seed;
                end
            end
            ST_RUN: begin
                pend_d = stop_req;
                if (bound) begin
                    if (stop_req) begin
                        state_d = ST_IDLE;
                        q_d     = '0;
                        pend_d  = 1'b0;
                    end else begin
                        q_d    = shifted;
                        dir_d  = dir_n;
                        tick_d = 1'b1;
                        step_d = step_q + SCW'(1);
                        if (step_q == LAST_STEP) state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                mode_d = mode_q + 2'd1;
                if (stop) begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            mode_q  <= MODE_ROTL;
            dir_q   <= DIR_LEFT;
            step_q  <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
        end
    end

    assign q         = q_q;
    assign mode      = mode_q;
    assign step_tick = tick_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/weddinglight_seq.md
# weddinglight_seq

Pattern sequencer for the 16-bit wedding-light shifter datapath. Steps a light register at a programmable rate and cycles through four shift patterns (rotate-left, rotate-right, fill, bounce), changing pattern after a fixed number of steps. It sits between the board-level start/stop controls and the LED output bus. It owns all sequencing, so the shifter itself carries no mode logic.

## Interface
- `WIDTH`, 16: light register width; must be ≥ 2.
- `PRESCALE`, 4: clock cycles per step; must be ≥ 2.
- `STEPS_PER_MODE`, 16: shifts performed before advancing to the next pattern; must be ≥ 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: level, sampled only in IDLE.
- `stop` input 1: level, sampled in every non-IDLE state and in IDLE.
- `q` output WIDTH: light pattern, registered.
- `mode` output 2: current pattern, registered. 0 = ROTL, 1 = ROTR, 2 = FILL, 3 = BOUNCE.
- `step_tick` output 1: registered one-cycle pulse, high in the cycle `q` first shows a new shifted value.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, LOAD, RUN, NEXT. Reset puts the block in IDLE with `q`=0, `mode`=0, `step_tick`=0, `busy`=0, and all counters at 0.
- IDLE:
  - `start`=1 and `stop`=0 goes to LOAD.
  - `start`=1 and `stop`=1 together stays in IDLE (stop wins).
  - `mode` keeps its last value; it is not reset by stop.
- LOAD: one cycle. Loads the seed into `q` and clears the prescaler and the step counter. Goes to RUN.
  - ROTL seed 0x0001; ROTR seed 0x8000; FILL seed 0x0000; BOUNCE seed 0x0001 with direction set to left.
- RUN: the prescaler counts 0..PRESCALE-1. When it reaches PRESCALE-1, that cycle is the step boundary:
  - ROTL: `q` = {q[W-2:0], q[W-1]}.
  - ROTR: `q` = {q[0], q[W-1:1]}.
  - FILL: `q` = {q[W-2:0], 1'b1}.
  - BOUNCE: shift left while the direction is left. When the shifted result has bit W-1 set, the direction flips to right. Shift right while the direction is right. When the shifted result has bit 0 set, the direction flips to left. The light never leaves the register.
  - The step counter increments on each boundary. The boundary that performs shift number STEPS_PER_MODE goes to NEXT.
- NEXT: one cycle. `mode` = `mode`+1 mod 4 (3 wraps to 0). Goes to LOAD.
- Stop while in RUN: `stop`=1 at any cycle sets a pending flag. At the next step boundary the block does not shift. Instead it goes to IDLE with `q`=0 and `step_tick`=0.
- Stop while in LOAD or NEXT: goes to IDLE on the next edge with `q`=0. In NEXT, the mode increment still occurs.
- Stop and the final step boundary in the same cycle: stop wins, the block goes to IDLE, and `mode` does not advance.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously).

## Timing
- Reference point: `start` is high in IDLE at cycle 0.
  - Cycle 1: LOAD, `busy`=1.
  - Cycle 2: RUN, `q`=seed, prescaler at 0.
- Step k (k ≥ 1) becomes visible on `q`, with `step_tick`=1, at cycle 2 + k·PRESCALE.
- The final step of a mode appears at cycle c:
  - NEXT is at c.
  - LOAD is at c+1, where the new `mode` is visible.
  - RUN is at c+2, with the new seed on `q`.
- The pattern-to-pattern gap is therefore 2 cycles plus one prescale period before the first new step.
- Stop latency: at most PRESCALE cycles from `stop` to `busy`=0.

## Configuration
- `WEDDINGLIGHT_HOLD_EN`: adds a `hold` input port, 1 bit.
  - While `hold`=1 in RUN, the prescaler, step counter, `q` and direction are frozen, and `step_tick`=0.
  - A stop request still latches during hold and takes effect at the first boundary after `hold` falls.
  - `hold` has no effect in IDLE, LOAD or NEXT.
- Without the macro, the port does not exist and the block behaves as if `hold`=0.

## Structure
- Package `weddinglight_pkg` holds:
  - the state enum;
  - the 2-bit mode codes;
  - the seed constants per mode;
  - the direction encoding.
- One sub-module, `weddinglight_prescaler`, contains the counter, the clear input, the hold input and the boundary strobe output.
- Shift logic and the FSM stay in the top module.

## Test plan
All scenarios use the defaults (WIDTH=16, PRESCALE=4, STEPS_PER_MODE=16).
- Reset: hold `rst`=0 for 3 cycles, then release with `start`=0. Expect `q`=0, `mode`=0, `busy`=0 and no `step_tick` for 50 cycles.
- ROTL timing: `start` pulse at cycle 0. Expect `q`=0x0001 at cycle 2, 0x0002 with `step_tick` at cycle 6, 0x0004 at cycle 10, 0x0001 at cycle 66, `mode`=1 at cycle 67, and `q`=0x8000 at cycle 68.
- FILL and BOUNCE: run continuously.
  - End of mode 2: `q`=0xFFFF.
  - Mode 3: after step 15, `q`=0x8000; after step 16, `q`=0x4000.
  - After mode 3, `mode` wraps to 0 and `q`=0x0001.
- Stop: assert `stop` one cycle after the step 3 boundary. Expect no further shift, `busy`=0, `q`=0 at the next boundary (cycle 18), and `mode` unchanged.
- Simultaneous events:
  - `start` and `stop` high together in IDLE: block stays IDLE.
  - `stop` on the final boundary of mode 0: IDLE with `mode`=0.
- Mid-run reset: `rst`=0 at cycle 30. Outputs are 0 within the same cycle. A restart then begins at `mode`=0.
